flag_branch_unit: RTL and testbench

FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

---
 rtl/flag_branch_unit.sv | 122 ++++++++++++
 tb/tb_flag_branch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// Architectural Z/V/N flag register plus a two-state branch resolver.
// It evaluates the condition codes on flags forwarded from the ALU in the same cycle.
module flag_branch_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_wr_en,
  input  logic [2:0] flag_mask,
  input  logic       alu_zero,
  input  logic       alu_ovfl,
  input  logic       alu_neg,
  input  logic       br_valid,
  input  logic [2:0] br_cond,
  output logic       br_ready,
  output logic       br_done,
  output logic       br_taken,
  input  logic       br_ack,
  input  logic       flush,
  output logic [2:0] flags_out
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DONE = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    COND_NE  = 3'b000,
    COND_EQ  = 3'b001,
    COND_GT  = 3'b010,
    COND_LT  = 3'b011,
    COND_GE  = 3'b100,
    COND_LE  = 3'b101,
    COND_OV  = 3'b110,
    COND_AL  = 3'b111
  } cond_t;

  localparam int Z_BIT = 2;
  localparam int V_BIT = 1;
  localparam int N_BIT = 0;

  state_t     state;
  logic [2:0] flags_q;
  logic [2:0] alu_flags;
  logic [2:0] flag_upd;
  logic [2:0] fwd_flags;
  logic       cond_met;
  logic       fz, fv, fn;

  assign alu_flags = {alu_zero, alu_ovfl, alu_neg};
  assign flag_upd  = {3{flag_wr_en}} & flag_mask;
  // Bits being written this cycle come straight from the ALU; the rest come from the register.
  assign fwd_flags = (flag_upd & alu_flags) | (~flag_upd & flags_q);
  assign fz        = fwd_flags[Z_BIT];
  assign fv        = fwd_flags[V_BIT];
  assign fn        = fwd_flags[N_BIT];
  assign flags_out = flags_q;

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    cond_met = 1'b0;
    case (cond_t'(br_cond))
      COND_NE: cond_met = ~fz;
      COND_EQ: cond_met = fz;
      COND_GT: cond_met = ~fz & ~fn;
      COND_LT: cond_met = fn;
      COND_GE: cond_met = fz | (~fz & ~fn);
      COND_LE: cond_met = fn | fz;
      COND_OV: cond_met = fv;
      COND_AL: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= fwd_flags;
    end
  end

  // Flush outranks both acceptance and acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      br_ready <= 1'b1;
      br_done  <= 1'b0;
      br_taken <= 1'b0;
    end else if (flush) begin
      state    <= IDLE;
      br_ready <= 1'b1;
      br_done  <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (br_valid) begin
            state    <= DONE;
            br_ready <= 1'b0;
            br_done  <= 1'b1;
            br_taken <= cond_met;
          end
        end
        DONE: begin
          if (br_ack) begin
            state    <= IDLE;
            br_ready <= 1'b1;
            br_done  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          br_ready <= 1'b1;
          br_done  <= 1'b0;
          br_taken <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit with hand-computed expectations.
// The bench drives inputs 1 ns after each rising edge and samples outputs at the same point.
module tb_flag_branch_unit;

  logic       clk;
  logic       rst_n;
  logic       flag_wr_en;
  logic [2:0] flag_mask;
  logic       alu_zero, alu_ovfl, alu_neg;
  logic       br_valid;
  logic [2:0] br_cond;
  logic       br_ready, br_done, br_taken;
  logic       br_ack;
  logic       flush;
  logic [2:0] flags_out;

  int n_checks = 0;
  int n_fail   = 0;

  flag_branch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flag_wr_en (flag_wr_en),
    .flag_mask  (flag_mask),
    .alu_zero   (alu_zero),
    .alu_ovfl   (alu_ovfl),
    .alu_neg    (alu_neg),
    .br_valid   (br_valid),
    .br_cond    (br_cond),
    .br_ready   (br_ready),
    .br_done    (br_done),
    .br_taken   (br_taken),
    .br_ack     (br_ack),
    .flush      (flush),
    .flags_out  (flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flag_wr_en = 1'b0;
    flag_mask  = 3'b000;
    alu_zero   = 1'b0;
    alu_ovfl   = 1'b0;
    alu_neg    = 1'b0;
    br_valid   = 1'b0;
    br_cond    = 3'b000;
    br_ack     = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic write_flags(input logic [2:0] mask, input logic [2:0] zvn);
    flag_wr_en = 1'b1;
    flag_mask  = mask;
    {alu_zero, alu_ovfl, alu_neg} = zvn;
  endtask

  // Accept one request, check the outcome, then acknowledge back to IDLE.
  task automatic branch(input string tag, input logic [2:0] cond, input logic exp_taken);
    br_valid = 1'b1;
    br_cond  = cond;
    step();
    br_valid   = 1'b0;
    flag_wr_en = 1'b0;
    check({tag, "_done"}, {7'd0, br_done}, 8'd1);
    check({tag, "_taken"}, {7'd0, br_taken}, {7'd0, exp_taken});
    br_ack = 1'b1;
    step();
    br_ack = 1'b0;
    check({tag, "_back_idle"}, {7'd0, br_ready}, 8'd1);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_flags", {5'd0, flags_out}, 8'h00);
    check("rst_ready", {7'd0, br_ready}, 8'd1);
    check("rst_done",  {7'd0, br_done},  8'd0);
    check("rst_taken", {7'd0, br_taken}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Always-taken, then ack returns to IDLE.
    br_valid = 1'b1;
    br_cond  = 3'b111;
    step();
    br_valid = 1'b0;
    check("al_done",  {7'd0, br_done},  8'd1);
    check("al_taken", {7'd0, br_taken}, 8'd1);
    check("al_ready", {7'd0, br_ready}, 8'd0);
    br_ack = 1'b1;
    step();
    br_ack = 1'b0;
    check("al_ready_after_ack", {7'd0, br_ready}, 8'd1);
    check("al_done_after_ack",  {7'd0, br_done},  8'd0);

    // Ack while in IDLE is ignored.
    br_ack = 1'b1;
    step();
    br_ack = 1'b0;
    check("ack_idle_ready", {7'd0, br_ready}, 8'd1);
    check("ack_idle_done",  {7'd0, br_done},  8'd0);

    // Same-cycle flag write forwarded into EQ.
    write_flags(3'b111, 3'b100);
    branch("fwd_eq", 3'b001, 1'b1);
    check("fwd_eq_flags", {5'd0, flags_out}, 8'h04);

    // Set Z=0 V=1 N=1, then clear only N; the unmasked ALU bits are driven high to prove masking.
    write_flags(3'b111, 3'b011);
    step();
    check("set_011", {5'd0, flags_out}, 8'h03);
    write_flags(3'b001, 3'b110);
    step();
    flag_wr_en = 1'b0;
    check("mask_n_only", {5'd0, flags_out}, 8'h02);
    branch("gt", 3'b010, 1'b1);
    branch("ov", 3'b110, 1'b1);
    branch("lt", 3'b011, 1'b0);
    branch("ne", 3'b000, 1'b1);

    // Hold DONE for three cycles with valid high while Z toggles.
    branch_hold();

    // Flags now Z=1 V=1 N=0.
    branch("le", 3'b101, 1'b1);
    branch("ge", 3'b100, 1'b1);
    // Forwarding overrides the register: Z cleared in the accepting cycle.
    write_flags(3'b100, 3'b000);
    branch("fwd_ne_reg", 3'b001, 1'b0);
    check("fwd_z_cleared", {5'd0, flags_out}, 8'h02);

    // Flush blocks acceptance in IDLE.
    flush    = 1'b1;
    br_valid = 1'b1;
    br_cond  = 3'b111;
    step();
    check("flush_idle_done",  {7'd0, br_done},  8'd0);
    check("flush_idle_ready", {7'd0, br_ready}, 8'd1);
    flush = 1'b0;
    step();
    br_valid = 1'b0;
    check("post_flush_accept", {7'd0, br_taken}, 8'd1);
    // Flush together with ack in DONE.
    flush  = 1'b1;
    br_ack = 1'b1;
    step();
    flush  = 1'b0;
    br_ack = 1'b0;
    check("flush_ack_ready", {7'd0, br_ready}, 8'd1);
    check("flush_ack_done",  {7'd0, br_done},  8'd0);
    check("flush_ack_taken", {7'd0, br_taken}, 8'd0);

    // Mid-cycle asynchronous reset while in DONE with flags 111.
    write_flags(3'b111, 3'b111);
    br_valid = 1'b1;
    br_cond  = 3'b111;
    step();
    idle_inputs();
    check("pre_rst_flags", {5'd0, flags_out}, 8'h07);
    check("pre_rst_done",  {7'd0, br_done},   8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_flags", {5'd0, flags_out}, 8'h00);
    check("async_rst_ready", {7'd0, br_ready},  8'd1);
    check("async_rst_done",  {7'd0, br_done},   8'd0);
    check("async_rst_taken", {7'd0, br_taken},  8'd0);
    // Edge during reset updates nothing.
    write_flags(3'b111, 3'b111);
    br_valid = 1'b1;
    step();
    check("rst_edge_flags", {5'd0, flags_out}, 8'h00);
    check("rst_edge_done",  {7'd0, br_done},   8'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    branch("after_rst", 3'b000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  task automatic branch_hold();
    br_valid = 1'b1;
    br_cond  = 3'b001;
    step();
    check("hold_accept_taken", {7'd0, br_taken}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      write_flags(3'b100, (i % 2 == 0) ? 3'b100 : 3'b000);
      step();
      check("hold_done",  {7'd0, br_done},  8'd1);
      check("hold_taken", {7'd0, br_taken}, 8'd0);
      check("hold_ready", {7'd0, br_ready}, 8'd0);
      check("hold_flags", {5'd0, flags_out}, (i % 2 == 0) ? 8'h06 : 8'h02);
    end
    flag_wr_en = 1'b0;
    br_valid   = 1'b0;
    br_ack     = 1'b1;
    step();
    br_ack = 1'b0;
    check("hold_release", {7'd0, br_ready}, 8'd1);
  endtask

endmodule
